ram_scan_ctrl: RTL and testbench

RAM_SCAN_CTRL -- requirements
Module: ram_scan_ctrl

---
 rtl/ram_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_ram_scan_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ram_scan_ctrl.sv
// RAM scan controller: walks length words from base_addr, accumulating sum/max/min/key-match count.
// Optional clear-on-read (each read followed by a zeroing write) is built when RAM_SCAN_CLEAR_EN is defined.
module ram_scan_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 6
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [ADDR_WIDTH:0]              length,
  input  logic [DATA_WIDTH-1:0]            key,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  output logic                             ram_read,
  output logic                             ram_write,
  output logic [DATA_WIDTH-1:0]            ram_wdata,
  input  logic [DATA_WIDTH-1:0]            ram_rdata,
  output logic                             busy,
  output logic                             done,
  output logic [ADDR_WIDTH+DATA_WIDTH:0]   sum,
  output logic [DATA_WIDTH-1:0]            max_val,
  output logic [DATA_WIDTH-1:0]            min_val,
  output logic [ADDR_WIDTH:0]              match_cnt
);

  localparam int SW = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

  typedef enum logic [1:0] {IDLE, READ, CLEAR, DONE} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH:0]     rem_q;
  logic [DATA_WIDTH-1:0]   key_q;
  logic                    read_q, busy_q, done_q;
  logic [SW-1:0]           sum_q, sum_d;
  logic [DATA_WIDTH-1:0]   max_q, max_d, min_q, min_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic                    last;

  // Accumulator updates only ever commit in READ, where ram_rdata is driven.
  always_comb begin
    sum_d = sum_q + {{(ADDR_WIDTH+1){1'b0}}, ram_rdata};
    max_d = (ram_rdata > max_q) ? ram_rdata : max_q;
    min_d = (ram_rdata < min_q) ? ram_rdata : min_q;
    cnt_d = cnt_q + {{ADDR_WIDTH{1'b0}}, (ram_rdata == key_q)};
    last  = (rem_q == CNT_ONE);
  end

`ifdef RAM_SCAN_CLEAR_EN
  logic write_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      key_q   <= '0;
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      max_q   <= '0;
      min_q   <= '1;
      cnt_q   <= '0;
`ifdef RAM_SCAN_CLEAR_EN
      write_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            key_q <= key;
            sum_q <= '0;
            max_q <= '0;
            min_q <= '1;
            cnt_q <= '0;
            rem_q <= length;
            if (length == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= READ;
              addr_q  <= base_addr;
              read_q  <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        READ: begin
          sum_q <= sum_d;
          max_q <= max_d;
          min_q <= min_d;
          cnt_q <= cnt_d;
`ifdef RAM_SCAN_CLEAR_EN
          // Zero the word just read at the same address on the next cycle.
          state_q <= CLEAR;
          read_q  <= 1'b0;
          write_q <= 1'b1;
`else
          if (last) begin
            state_q <= DONE;
            read_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            addr_q <= addr_q + ADDR_ONE;
            rem_q  <= rem_q - CNT_ONE;
          end
`endif
        end
`ifdef RAM_SCAN_CLEAR_EN
        CLEAR: begin
          write_q <= 1'b0;
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= READ;
            read_q  <= 1'b1;
            addr_q  <= addr_q + ADDR_ONE;
            rem_q   <= rem_q - CNT_ONE;
          end
        end
`endif
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RAM_SCAN_CLEAR_EN
  assign ram_write = write_q;
`else
  assign ram_write = 1'b0;
`endif
  assign ram_wdata = '0;
  assign ram_addr  = addr_q;
  assign ram_read  = read_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign max_val   = max_q;
  assign min_val   = min_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Directed bench for ram_scan_ctrl with a behavioural RAM and a scoreboard of expected scan results.
module tb_ram_scan_ctrl;
  localparam int AW = 9, DW = 6, SW = AW + DW + 1;
`ifdef RAM_SCAN_CLEAR_EN
  localparam int LATM = 2;
`else
  localparam int LATM = 1;
`endif

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic [DW-1:0] key = '0;
  logic [AW-1:0] ram_addr;
  logic          ram_read, ram_write, busy, done;
  logic [DW-1:0] ram_wdata, max_val, min_val;
  logic [SW-1:0] sum;
  logic [AW:0]   match_cnt;
  wire  [DW-1:0] ram_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  typedef struct {
    logic [SW-1:0] sum;
    logic [DW-1:0] mx, mn;
    logic [AW:0]   cnt;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   addr_log[$];
  int   errors = 0, checks = 0, reads = 0, writes = 0, dones = 0;

  ram_scan_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length), .key(key),
    .ram_addr(ram_addr), .ram_read(ram_read), .ram_write(ram_write), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .done(done), .sum(sum), .max_val(max_val),
    .min_val(min_val), .match_cnt(match_cnt)
  );

  assign ram_rdata = ram_read ? mem[ram_addr] : 'z;

  always #5 clk = ~clk;

  // RAM write port and bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_read) begin reads++; addr_log.push_back(int'(ram_addr)); end
      if (ram_write) begin writes++; mem[ram_addr] = ram_wdata; end
      if (done) dones++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int s, input int mx, input int mn, input int c, input int len);
    exp_t e;
    e.sum = SW'(s); e.mx = DW'(mx); e.mn = DW'(mn); e.cnt = (AW+1)'(c); e.lat = LATM * len + 1;
    return e;
  endfunction

  function automatic exp_t model(input int b, input int len, input logic [DW-1:0] k);
    int s = 0, mx = 0, mn = (1 << DW) - 1, c = 0;
    for (int i = 0; i < len; i++) begin
      int w;
      w = int'(mem[(b + i) % (1 << AW)]);
      s += w;
      if (w > mx) mx = w;
      if (w < mn) mn = w;
      if (w == int'(k)) c++;
    end
    return mk(s, mx, mn, c, len);
  endfunction

  task automatic run_scan(input string tag, input int b, input int len, input int k, input exp_t e);
    exp_t got;
    int n;
    sb.push_back(e);
    addr_log.delete();
    @(negedge clk);
    start = 1'b1; base_addr = AW'(b); length = (AW+1)'(len); key = DW'(k);
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (n == 1) check({tag, "_busy"}, busy, (len > 0) ? 1 : 0);
      if (done) break;
    end
    got = sb.pop_front();
    check({tag, "_latency"}, n, got.lat);
    check({tag, "_sum"}, sum, got.sum);
    check({tag, "_max"}, max_val, got.mx);
    check({tag, "_min"}, min_val, got.mn);
    check({tag, "_cnt"}, match_cnt, got.cnt);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int r0, b, l, d0;
    logic [DW-1:0] k;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom_range(1, 62));

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_read", ram_read, 0);
    check("rst_write", ram_write, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_sum", sum, 0);
    check("rst_max", max_val, 0);
    check("rst_min", min_val, 63);
    check("rst_cnt", match_cnt, 0);
    rst_n = 1'b1;

    mem[0] = 6'd5; mem[1] = 6'd63; mem[2] = 6'd0; mem[3] = 6'd5;
    run_scan("basic", 0, 4, 5, mk(73, 63, 0, 2, 4));
    repeat (3) @(negedge clk);
    check("hold_sum", sum, 73);
    check("hold_cnt", match_cnt, 2);

    mem[510] = 6'd1; mem[511] = 6'd2; mem[0] = 6'd3; mem[1] = 6'd4;
    run_scan("wrap", 510, 4, 0, mk(10, 4, 1, 0, 4));
    check("wrap_nreads", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      check("wrap_a0", addr_log[0], 510);
      check("wrap_a1", addr_log[1], 511);
      check("wrap_a2", addr_log[2], 0);
      check("wrap_a3", addr_log[3], 1);
    end

    r0 = reads;
    run_scan("len0", 0, 0, 9, mk(0, 0, 63, 0, 0));
    check("len0_noread", reads, r0);

    b = $urandom_range(0, 511); l = $urandom_range(1, 40); k = mem[b];
    run_scan("rand", b, l, int'(k), model(b, l, k));

    for (int i = 0; i < (1 << AW); i++) mem[i] = 6'd63;
    run_scan("full", 0, 512, 63, mk(32256, 63, 63, 512, 512));

    // Mid-scan restart attempt then reset abort.
    d0 = dones;
    addr_log.delete();
    @(negedge clk);
    start = 1'b1; base_addr = '0; length = 11'd20; key = '0;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; base_addr = 9'd100; length = 11'd5;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(negedge clk);
    check("ign_busy", busy, 1);
    for (int i = 0; i < addr_log.size(); i++) check("ign_addr", addr_log[i], i);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_read", ram_read, 0);
    check("abort_addr", ram_addr, 0);
    check("abort_sum", sum, 0);
    check("abort_max", max_val, 0);
    check("abort_min", min_val, 63);
    check("abort_cnt", match_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_nodone", dones, d0);
    check("abort_idle", busy, 0);

`ifdef RAM_SCAN_CLEAR_EN
    mem[8] = 6'd7; mem[9] = 6'd1; mem[10] = 6'd7;
    run_scan("clr", 8, 3, 7, mk(15, 7, 1, 2, 3));
    check("clr_m8", mem[8], 0);
    check("clr_m9", mem[9], 0);
    check("clr_m10", mem[10], 0);
`else
    check("nowrite", writes, 0);
    check("mem_kept", mem[3], 63);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
